// File: rtl/vector_dot_stream.sv
// rtl/vector_dot_stream.sv - streaming dot-product / reduction engine with saturating accumulator

module vector_dot_stream #(
  parameter int LANES = 4,
  parameter int WIDTH = 16,
  parameter int ACC_W = 40
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [1:0]             in_op,
  input  logic [ACC_W-1:0]       in_r2,
  input  logic [LANES*WIDTH-1:0] in_v1,
  input  logic [LANES*WIDTH-1:0] in_v2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_result,
  output logic                   out_sat,
  output logic [15:0]            out_beats,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

  localparam logic [1:0] OP_DOT    = 2'd0;
  localparam logic [1:0] OP_DOTA   = 2'd1;
  localparam logic [1:0] OP_REDUCE = 2'd2;
  localparam logic [1:0] OP_MAX    = 2'd3;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t state_q, state_d;

  logic       accept;
  logic       first;
  logic [1:0] op_q;

  // input capture stage
  logic [LANES*WIDTH-1:0] s0_v1, s0_v2;
  logic                   s0_valid, s0_last;

  // P1: per-lane terms
  logic signed [WIDTH-1:0]   lane_a   [LANES];
  logic signed [2*WIDTH-1:0] lane_ea  [LANES];
  logic signed [2*WIDTH-1:0] lane_eb  [LANES];
  logic signed [2*WIDTH-1:0] lane_prod[LANES];
  logic signed [ACC_W-1:0]   term_d   [LANES];
  logic signed [ACC_W-1:0]   p1_term  [LANES];
  logic                      p1_valid, p1_last;

  // P2: lane combine
  logic signed [ACC_W-1:0] sum_d, max_d, comb_d;
  logic signed [ACC_W-1:0] p2_val;
  logic                    p2_valid, p2_last;

  // ACC stage
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W:0]   sum_ext;
  logic                    sum_ovf;
  logic                    sat;
  logic [15:0]             beats;

  assign in_ready = !flush && (state_q == IDLE || state_q == ACCUM);
  assign accept   = in_valid && in_ready;
  assign first    = accept && (state_q == IDLE);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state and status outputs; flush overrides every state
  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE:  if (accept) state_d = in_last ? DRAIN : ACCUM;
      ACCUM: if (accept && in_last) state_d = DRAIN;
      DRAIN: if (p2_valid && p2_last) state_d = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // pipeline valid/last tracking, emptied by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s0_last  <= 1'b0;
      p1_valid <= 1'b0;
      p1_last  <= 1'b0;
      p2_valid <= 1'b0;
      p2_last  <= 1'b0;
    end else if (flush) begin
      s0_valid <= 1'b0;
      p1_valid <= 1'b0;
      p2_valid <= 1'b0;
    end else begin
      s0_valid <= accept;
      s0_last  <= in_last;
      p1_valid <= s0_valid;
      p1_last  <= s0_last;
      p2_valid <= p1_valid;
      p2_last  <= p1_last;
    end
  end

  // per-lane product (dot modes) or sign-extended element (reduce/max)
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_a[i]    = s0_v1[i*WIDTH +: WIDTH];
      lane_ea[i]   = {{WIDTH{s0_v1[i*WIDTH+WIDTH-1]}}, s0_v1[i*WIDTH +: WIDTH]};
      lane_eb[i]   = {{WIDTH{s0_v2[i*WIDTH+WIDTH-1]}}, s0_v2[i*WIDTH +: WIDTH]};
      lane_prod[i] = lane_ea[i] * lane_eb[i];
      if (op_q == OP_REDUCE || op_q == OP_MAX)
        term_d[i] = {{(ACC_W-WIDTH){lane_a[i][WIDTH-1]}}, lane_a[i]};
      else
        term_d[i] = {{(ACC_W-2*WIDTH){lane_prod[i][2*WIDTH-1]}}, lane_prod[i]};
    end
  end

  // lane sum and lane max; the sum cannot overflow at ACC_W
  always_comb begin
    sum_d = '0;
    max_d = p1_term[0];
    for (int i = 0; i < LANES; i++) begin
      sum_d = sum_d + p1_term[i];
      if (p1_term[i] > max_d) max_d = p1_term[i];
    end
    comb_d = (op_q == OP_MAX) ? max_d : sum_d;
  end

  // datapath registers; only the valids above need reset or flush
  always_ff @(posedge clk) begin
    if (accept) begin
      s0_v1 <= in_v1;
      s0_v2 <= in_v2;
    end
    for (int i = 0; i < LANES; i++) p1_term[i] <= term_d[i];
    p2_val <= comb_d;
  end

  assign sum_ext = {acc[ACC_W-1], acc} + {p2_val[ACC_W-1], p2_val};
  assign sum_ovf = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];

  // accumulator, sticky saturation flag, beat counter and latched op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      sat   <= 1'b0;
      beats <= '0;
      op_q  <= OP_DOT;
    end else if (first) begin
      op_q  <= in_op;
      sat   <= 1'b0;
      beats <= 16'd1;
      case (in_op)
        OP_DOTA: acc <= in_r2;
        OP_MAX:  acc <= ACC_MIN;
        default: acc <= '0;
      endcase
    end else begin
      if (accept && beats != 16'hFFFF) beats <= beats + 16'd1;
      if (p2_valid) begin
        if (op_q == OP_MAX) begin
          if (p2_val > acc) acc <= p2_val;
        end else if (sum_ovf) begin
          acc <= sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
          sat <= 1'b1;
        end else begin
          acc <= sum_ext[ACC_W-1:0];
        end
      end
    end
  end

  assign out_result = acc;
  assign out_sat    = sat;
  assign out_beats  = beats;

endmodule

// File: tb/tb_vector_dot_stream.sv
// tb/tb_vector_dot_stream.sv - scoreboard bench for vector_dot_stream

module tb_vector_dot_stream;

  typedef struct {
    logic [39:0] res;
    logic        sat;
    logic [15:0] beats;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, in_last;
  logic        out_valid, out_ready, out_sat, busy;
  logic [1:0]  in_op;
  logic [39:0] in_r2, out_result;
  logic [63:0] in_v1, in_v2;
  logic [15:0] out_beats;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   stalls = 0;

  vector_dot_stream dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_op(in_op), .in_r2(in_r2), .in_v1(in_v1), .in_v2(in_v2),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_sat(out_sat), .out_beats(out_beats), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] pack(input int l0, input int l1, input int l2, input int l3);
    return {l3[15:0], l2[15:0], l1[15:0], l0[15:0]};
  endfunction

  function automatic logic [39:0] s40(input longint v);
    return v[39:0];
  endfunction

  task automatic expect_out(input longint r, input logic s, input int b);
    exp_t e;
    e.res   = s40(r);
    e.sat   = s;
    e.beats = b[15:0];
    sb.push_back(e);
  endtask

  task automatic beat(input logic [1:0] op, input longint r2, input logic [63:0] v1,
                      input logic [63:0] v2, input logic last);
    int n;
    in_valid = 1'b1; in_op = op; in_r2 = s40(r2);
    in_v1 = v1; in_v2 = v2; in_last = last;
    n = 0;
    while (!in_ready && n < 100) begin
      stalls++;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("beat_timeout", 64'(n), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) check("idle_timeout", 64'(n), 64'd0);
  endtask

  // monitor: pop and compare on every output handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("out_result", 64'(out_result), 64'(e.res));
          check("out_sat", 64'(out_sat), 64'(e.sat));
          check("out_beats", 64'(out_beats), 64'(e.beats));
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_op = 2'd0; in_r2 = '0; in_v1 = '0; in_v2 = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", 64'(out_result), 64'd0);
    check("rst_sat", 64'(out_sat), 64'd0);
    check("rst_beats", 64'(out_beats), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // DOT single beat with latency measurement
    expect_out(70, 1'b0, 1);
    beat(2'd0, 0, pack(1, 2, 3, 4), pack(5, 6, 7, 8), 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 64'(n), 64'd3);
    wait_idle();

    // DOTA back-to-back; op and seed on later beats must be ignored
    stalls = 0;
    expect_out(20, 1'b0, 3);
    beat(2'd1, -100, pack(1, 1, 1, 1), pack(10, 10, 10, 10), 1'b0);
    beat(2'd3, 5000, pack(1, 1, 1, 1), pack(10, 10, 10, 10), 1'b0);
    beat(2'd2, 777,  pack(1, 1, 1, 1), pack(10, 10, 10, 10), 1'b1);
    check("dota_no_stall", 64'(stalls), 64'd0);
    wait_idle();

    // REDUCE ignores v2
    expect_out(65538, 1'b0, 2);
    beat(2'd2, 0, pack(-5, 7, 0, 32767), {$urandom, $urandom}, 1'b0);
    beat(2'd2, 0, pack(-5, 7, 0, 32767), {$urandom, $urandom}, 1'b1);
    wait_idle();

    // MAX of all-negative elements
    expect_out(-1, 1'b0, 2);
    beat(2'd3, 0, pack(-3, -9, -1, -7), pack(9, 9, 9, 9), 1'b0);
    beat(2'd3, 0, pack(-20, -2, -30, -4), pack(9, 9, 9, 9), 1'b1);
    wait_idle();

    // saturation: 130 beats of 4 * 2^30
    expect_out(64'd549755813887, 1'b1, 130);
    for (int i = 0; i < 130; i++)
      beat(2'd0, 0, 64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000, i == 129);
    wait_idle();

    // backpressure: result held for 10 cycles
    out_ready = 1'b0;
    expect_out(-14, 1'b0, 1);
    beat(2'd0, 0, pack(2, 3, 4, 5), pack(-1, -1, -1, -1), 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_valid_seen", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_result", 64'(out_result), 64'(s40(-14)));
      check("bp_sat", 64'(out_sat), 64'd0);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle", 64'(busy), 64'd0);
    check("bp_in_ready_after", 64'(in_ready), 64'd1);

    // flush after beat 2 of 5
    beat(2'd0, 0, pack(1, 1, 1, 1), pack(1, 1, 1, 1), 1'b0);
    beat(2'd0, 0, pack(1, 1, 1, 1), pack(1, 1, 1, 1), 1'b0);
    in_valid = 1'b1; in_v1 = pack(1, 1, 1, 1); in_v2 = pack(1, 1, 1, 1); flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle", 64'(busy), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    check("flush_no_out", 64'(out_valid), 64'd0);

    // asynchronous reset mid-ACCUM
    beat(2'd1, 55, pack(3, 3, 3, 3), pack(3, 3, 3, 3), 1'b0);
    beat(2'd1, 55, pack(3, 3, 3, 3), pack(3, 3, 3, 3), 1'b0);
    rst_n = 1'b0;
    #1;
    check("amid_busy", 64'(busy), 64'd0);
    check("amid_out_valid", 64'(out_valid), 64'd0);
    check("amid_in_ready", 64'(in_ready), 64'd1);
    check("amid_result", 64'(out_result), 64'd0);
    check("amid_sat", 64'(out_sat), 64'd0);
    check("amid_beats", 64'(out_beats), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // clean DOT vector after reset
    expect_out(-2, 1'b0, 2);
    beat(2'd0, 0, pack(1, 2, 3, 4), pack(1, 1, 1, 1), 1'b0);
    beat(2'd0, 0, pack(-1, -1, -1, -1), pack(3, 3, 3, 3), 1'b1);
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
